// File: rtl/io_cond_pkg.sv
// Shared defaults for the board input conditioning stage and the LSU I/O widths.
package io_cond_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned SW_W_DEF            = 32;
    localparam int unsigned BTN_W_DEF           = 4;

    // Debounce counter width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-bit button conditioner: synchroniser, polarity fix, debounce counter
// and a one-cycle pulse on each accepted press.
module debounce_cell
    import io_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   press_q, press_d;
    logic                   sample;

    // Sync flops reset to the released pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sample == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sample;
            cnt_d    = '0;
            press_d  = sample;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/io_input_cond.sv
// Board switch/button conditioning ahead of the LSU I/O read ports: per-button
// debounce cells plus a switch word that only ever updates as a whole.
module io_input_cond
    import io_cond_pkg::*;
#(
    parameter int unsigned SW_W            = SW_W_DEF,
    parameter int unsigned BTN_W           = BTN_W_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [SW_W-1:0]  i_sw_raw,
    input  logic [BTN_W-1:0] i_btn_raw,
    output logic [SW_W-1:0]  o_io_sw,
    output logic [BTN_W-1:0] o_io_btn,
    output logic [BTN_W-1:0] o_btn_press
);

    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        debounce_cell #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (BTN_ACTIVE_LOW)
        ) u_cell (
            .clk  (i_clk),
            .rst_n(i_rst_n),
            .raw  (i_btn_raw[i]),
            .level(o_io_btn[i]),
            .press(o_btn_press[i])
        );
    end

    logic [SW_W-1:0]  sw_sync_q [SYNC_STAGES];
    logic [SW_W-1:0]  sync_sw;
    logic [SW_W-1:0]  sw_prev_q;
    logic [SW_W-1:0]  sw_q, sw_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sw_sync_q[s] <= '0;
            end
        end else begin
            sw_sync_q[0] <= i_sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sw_sync_q[s] <= sw_sync_q[s-1];
            end
        end
    end

    assign sync_sw = sw_sync_q[SYNC_STAGES-1];

    // Any bit moving restarts the shared count, so a partial word is never taken.
    always_comb begin
        scnt_d = scnt_q;
        sw_d   = sw_q;
        if ((sync_sw == sw_q) || (sync_sw != sw_prev_q)) begin
            scnt_d = '0;
        end else if (scnt_q == CNT_MAX) begin
            sw_d   = sync_sw;
            scnt_d = '0;
        end else begin
            scnt_d = scnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_prev_q <= '0;
            sw_q      <= '0;
            scnt_q    <= '0;
        end else begin
            sw_prev_q <= sync_sw;
            sw_q      <= sw_d;
            scnt_q    <= scnt_d;
        end
    end

    assign o_io_sw = sw_q;

endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, active-low buttons.
module tb_io_input_cond;

    logic        clk;
    logic        rst_n;
    logic [31:0] sw_raw;
    logic [3:0]  btn_raw;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [3:0]  btn_press;

    int tests;
    int fails;

    typedef struct {
        logic [31:0] sw;
        logic [3:0]  btn;
        logic [3:0]  exp_btn;
        logic [3:0]  exp_press;
        logic [31:0] exp_sw;
    } vec_t;

    vec_t vecs[$];

    io_input_cond #(
        .SW_W           (32),
        .BTN_W          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sw_raw   (sw_raw),
        .i_btn_raw  (btn_raw),
        .o_io_sw    (io_sw),
        .o_io_btn   (io_btn),
        .o_btn_press(btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rows(input int n, input logic [31:0] sw, input logic [3:0] btn,
                        input logic [3:0] eb, input logic [3:0] ep, input logic [31:0] es);
        vec_t v;
        v.sw        = sw;
        v.btn       = btn;
        v.exp_btn   = eb;
        v.exp_press = ep;
        v.exp_sw    = es;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eb, input logic [3:0] ep);
        check({tag, "_btn"}, 32'(io_btn), 32'(eb));
        check({tag, "_press"}, 32'(btn_press), 32'(ep));
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        btn_raw = 4'hF;
        sw_raw  = 32'h0;

        // Row r is driven after one edge and checked after the next.
        rows(1, 32'h0, 4'hF, 4'h0, 4'h0, 32'h0);
        rows(5, 32'h0, 4'hE, 4'h0, 4'h0, 32'h0);
        rows(1, 32'h0, 4'hE, 4'h1, 4'h1, 32'h0);
        rows(2, 32'h0, 4'hE, 4'h1, 4'h0, 32'h0);
        rows(5, 32'h0, 4'hF, 4'h1, 4'h0, 32'h0);
        rows(2, 32'h0, 4'hF, 4'h0, 4'h0, 32'h0);
        rows(5, 32'h0, 4'h6, 4'h0, 4'h0, 32'h0);
        rows(1, 32'h0, 4'h6, 4'h9, 4'h9, 32'h0);
        rows(2, 32'h0, 4'h6, 4'h9, 4'h0, 32'h0);
        rows(5, 32'h0, 4'hF, 4'h9, 4'h0, 32'h0);
        rows(2, 32'h0, 4'hF, 4'h0, 4'h0, 32'h0);

        // Reset hold and release
        repeat (3) @(posedge clk);
        #1;
        check_outs("rst_hold", 4'h0, 4'h0);
        check("rst_hold_sw", io_sw, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_outs($sformatf("rst_idle%0d", k), 4'h0, 4'h0);
            check($sformatf("rst_idle%0d_sw", k), io_sw, 32'h0);
        end

        // Clean press/release and two simultaneous buttons
        for (int i = 0; i < vecs.size(); i++) begin
            sw_raw  = vecs[i].sw;
            btn_raw = vecs[i].btn;
            tick();
            check_outs($sformatf("tbl%0d", i), vecs[i].exp_btn, vecs[i].exp_press);
            check($sformatf("tbl%0d_sw", i), io_sw, vecs[i].exp_sw);
        end

        // Bounce on button 1 never gets through; a steady hold does
        for (int c = 0; c < 20; c++) begin
            btn_raw = (((c / 2) % 2) == 0) ? 4'hD : 4'hF;
            tick();
            check_outs($sformatf("bounce%0d", c), 4'h0, 4'h0);
        end
        btn_raw = 4'hD;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_outs($sformatf("bhold%0d", k), (k >= 6) ? 4'h2 : 4'h0,
                       (k == 6) ? 4'h2 : 4'h0);
        end
        btn_raw = 4'hF;
        repeat (8) tick();
        check_outs("brel", 4'h0, 4'h0);

        // Clean switch change
        sw_raw = 32'hA5A5_0003;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("sw_a%0d", k), io_sw, (k >= 7) ? 32'hA5A5_0003 : 32'h0);
        end

        // Switch change with bit 0 moving again mid-count
        sw_raw = 32'h5A5A_0001;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check($sformatf("sw_b%0d", k), io_sw,
                  (k >= 11) ? 32'h5A5A_0000 : 32'hA5A5_0003);
            if (k == 4) sw_raw = 32'h5A5A_0000;
        end

        // Asynchronous reset while button 0 counter sits at 3
        btn_raw = 4'hE;
        repeat (5) tick();
        check_outs("pre_arst", 4'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("arst", 4'h0, 4'h0);
        check("arst_sw", io_sw, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_outs($sformatf("post_arst%0d", k), (k >= 6) ? 4'h1 : 4'h0,
                       (k == 6) ? 4'h1 : 4'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
